inst_fetch_queue: RTL

//  Instruction prefetch queue between the instruction ROM and the IF/ID pipeline register.

---
 rtl/inst_fetch_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction prefetch queue that sits between the instruction ROM and the
//   IF/ID pipeline register. It drives the ROM word address, captures
//   {pc, inst} pairs into a circular FIFO, and presents the oldest entry to
//   decode through a valid/ready handshake. Fetch can run ahead while decode
//   is stalled. A branch/jump redirect (flush) discards all queued entries and
//   restarts fetch at the redirect address.
//
// Ports
//   clk           in   rising-edge clock
//   resetIn       in   asynchronous, active-high reset
//   enable        in   fetch permitted this cycle (gates push only)
//   flush         in   redirect request, discards all queued entries
//   redirectAddr  in   new fetch address, sampled when flush=1
//   romAddr       out  word address to the combinational ROM
//   romInst       in   ROM data for romAddr (same cycle)
//   deqReady      in   decode accepts the head entry this cycle
//   deqValid      out  head entry valid (= !empty)
//   deqInst       out  head instruction (0 when empty)
//   deqAddr       out  head instruction address (0 when empty)
//   count         out  number of occupied entries
//   full          out  count == DEPTH
//   empty         out  count == 0
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       resetIn,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          redirectAddr,
  output logic [ADDR_W-1:0]          romAddr,
  input  logic [DATA_W-1:0]          romInst,
  input  logic                       deqReady,
  output logic                       deqValid,
  output logic [DATA_W-1:0]          deqInst,
  output logic [ADDR_W-1:0]          deqAddr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  occ;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic              pop;
  logic              push;

  assign empty    = (occ == '0);
  assign full     = (occ == CNT_FULL);
  assign count    = occ;
  assign deqValid = !empty;
  assign romAddr  = fetch_pc;

  // A pop frees a slot in the same cycle, so a full queue can still accept
  // a new fetch while decode is draining it.
  assign pop  = deqValid & deqReady;
  assign push = enable & !flush & (!full | pop);

  // Head is read combinationally; forced to zero when nothing is queued so
  // decode never sees stale entries.
  assign deqAddr = empty ? '0 : mem_addr[rd_ptr];
  assign deqInst = empty ? '0 : mem_inst[rd_ptr];

  // Control state: pointers, occupancy and fetch PC. Flush overrides both
  // push and pop and restarts the queue from slot 0.
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else if (flush) begin
      fetch_pc <= redirectAddr;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Queue storage carries data only and needs no reset; occupancy gates
  // every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= fetch_pc;
      mem_inst[wr_ptr] <= romInst;
    end
  end

endmodule
